uart_rx_core: RTL and testbench

- 8N1 UART receiver, LSB first, for the fpga_core serial ports (rx, rx1).
- Converts an asynchronous serial line into bytes with a valid/ready handshake.
- Flags framing errors and overruns.
- Counterpart to the existing UART transmitter; runs in the 12 MHz core clock domain derived from the 50 MHz board clock.

---
 rtl/uart_rx_core.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 by default (8E1 with parity_err when UART_RX_PARITY_EN is
// defined), LSB first, mid-bit sampling, valid/ready holding register, error pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`endif

  // NOTE: synchronizer resets to all-ones so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // NOTE: all state and outputs use non-blocking assignments; later assignments in the
  // same cycle deliberately override the defaults at the top of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      baud_cnt <= baud_cnt + 1'b1;

      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (!rxs) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        // Confirming the start bit at mid-bit aligns every later sample to mid-bit.
        S_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt        <= '0;
            shift[bit_idx]  <= rxs;
            bit_idx         <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PARITY;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            par_bit  <= rxs;
            state    <= S_STOP;
          end
        end
`endif

        // Stop sampled at mid-bit leaves half a bit of margin for the next start edge.
        S_STOP: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_bit != ^shift) begin
                parity_err <= 1'b1;
              end else
`endif
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end

        // A held-low line delivers nothing until it returns to idle.
        S_BREAK: begin
          if (rxs) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            baud_cnt <= '0;
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frame-level reference model feeds an expected-byte
// queue and event counts; a monitor pops and compares whenever a byte is handed over.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int fe_exp = 0, fe_seen = 0;
  int ov_exp = 0, ov_seen = 0;
  int pe_exp = 0, pe_seen = 0;
  bit ready_rand = 1'b0;
  bit stalled = 1'b0;
  bit held = 1'b0;
  bit busy_seen = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit prev_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: runs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none (t=%0t)", rx_data, $time);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_seen++;
`endif
      if (frame_err || overrun) check("fe_ov_exclusive", 32'(frame_err & overrun), 32'd0);
      if (prev_hold && rx_valid) check("rx_data_stable", 32'(rx_data), 32'(prev_data));
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
      if (busy) busy_seen = 1'b1;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (ready_rand) rx_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Leaves the line at the stop-bit level; the caller decides what follows.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ par_flip);
    send_bit(stop_bit);
  endtask

  // Frame-level reference: what the receiver should report for one frame.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    if (!stop_bit)                fe_exp++;
    else if (PAR_EN && par_flip)  pe_exp++;
    else if (stalled && held)     ov_exp++;
    else begin
      exp_q.push_back(d);
      if (stalled) held = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    model_frame(d, stop_bit, par_flip);
    send_frame(d, stop_bit, par_flip);
    rx = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 400) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    check({tag, "_rx_data"},   32'(rx_data),   32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
`ifdef UART_RX_PARITY_EN
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(4);

    // Single byte, consumer always ready.
    rx_ready = 1'b1;
    frame(8'hA5, 1'b1, 1'b0);
    tick(4);
    wait_drain();
    check("a5_frame_err", 32'(fe_seen), 32'(fe_exp));
    check("a5_overrun",   32'(ov_seen), 32'(ov_exp));

    // Start-bit glitch shorter than half a bit.
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_rx_valid",  32'(rx_valid), 32'd0);
    check("glitch_frame_err", 32'(fe_seen), 32'(fe_exp));
    check("glitch_overrun",   32'(ov_seen), 32'(ov_exp));

    // Back-to-back bytes with a stalled consumer.
    rx_ready = 1'b0;
    stalled  = 1'b1;
    held     = 1'b0;
    frame(8'h3C, 1'b1, 1'b0);
    frame(8'hC3, 1'b1, 1'b0);
    tick(4);
    check("ovr_rx_valid", 32'(rx_valid), 32'd1);
    check("ovr_rx_data",  32'(rx_data),  32'h3C);
    check("ovr_count",    32'(ov_seen),  32'(ov_exp));
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    stalled  = 1'b0;
    held     = 1'b0;
    check("ovr_released", 32'(rx_valid), 32'd0);
    check("ovr_queue",    32'(exp_q.size()), 32'd0);

    // Bad stop bit followed by a long break, then a clean byte.
    rx_ready = 1'b1;
    model_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    tick(20 * CPB);
    check("break_rx_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    tick(2 * CPB);
    check("break_frame_err", 32'(fe_seen), 32'(fe_exp));
    frame(8'h12, 1'b1, 1'b0);
    tick(4);
    wait_drain();

    // Reset in the middle of a frame while a byte is pending.
    rx_ready = 1'b0;
    stalled  = 1'b1;
    held     = 1'b0;
    frame(8'h5A, 1'b1, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midrst");
    exp_q.delete();
    stalled = 1'b0;
    held    = 1'b0;
    rst = 1'b0;
    tick(8 * CPB);
    rx_ready = 1'b1;
    frame(8'h81, 1'b1, 1'b0);
    tick(4);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    // Wrong parity, then the same byte with correct even parity.
    frame(8'h07, 1'b1, 1'b1);
    tick(4);
    check("par_bad_pulse", 32'(pe_seen), 32'(pe_exp));
    check("par_bad_valid", 32'(rx_valid), 32'd0);
    frame(8'h07, 1'b1, 1'b0);
    tick(4);
    wait_drain();
`endif

    // Randomized traffic with a randomly stalling consumer.
    ready_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       stop_bit;
      logic       par_flip;
      d        = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
      par_flip = PAR_EN && ($urandom_range(0, 5) == 0);
      frame(d, stop_bit, par_flip);
      tick($urandom_range(CPB, 3 * CPB));
    end
    ready_rand = 1'b0;
    rx_ready   = 1'b1;
    tick(2);
    wait_drain();

    check("final_frame_err", 32'(fe_seen), 32'(fe_exp));
    check("final_overrun",   32'(ov_seen), 32'(ov_exp));
    check("final_parity",    32'(pe_seen), 32'(pe_exp));
    check("final_busy",      32'(busy),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
